// File: rtl/spi_slave.sv
// spi_slave: mode-programmable SPI slave with a one-byte transmit buffer and a
// one-byte receive register with unread/overrun flags.
//
// Ports:
//   clk, rst_n        system clock, synchronous active-low reset
//   cpol, cpha        SPI mode, captured only while deselected
//   sck, ss_n, mosi   asynchronous SPI bus inputs (synchronized internally)
//   miso, miso_oe     serial data out (MSB first) and its output enable
//   tx_data, tx_wr    byte to transmit and its write strobe
//   tx_full           transmit buffer holds an unsent byte
//   rx_data, rx_ne    last completed received byte and its unread flag
//   rx_rd             read acknowledge, clears rx_ne and rx_ovr
//   rx_ovr            sticky overrun flag
//   busy              selected and in the middle of a byte
//
// state  | meaning
// IDLE   | synchronized ss_n high, sck edges ignored
// ACTIVE | synchronized ss_n low, bits being exchanged
module spi_slave (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cpol,
  input  logic       cpha,
  input  logic       sck,
  input  logic       ss_n,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_wr,
  output logic       tx_full,
  output logic [7:0] rx_data,
  output logic       rx_ne,
  input  logic       rx_rd,
  output logic       rx_ovr,
  output logic       busy
);

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_e;

  state_e     state_q, state_d;
  logic       sck_s1_q, sck_s2_q, sck_prev_q;
  logic       ss_s1_q, ss_s2_q;
  logic       mosi_s1_q, mosi_s2_q;
  logic       cpol_q, cpol_d, cpha_q, cpha_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_sr_q, rx_sr_d;
  logic [7:0] tx_sr_q, tx_sr_d;
  logic [7:0] tx_buf_q, tx_buf_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       tx_full_q, tx_full_d;
  logic       rx_ne_q, rx_ne_d;
  logic       rx_ovr_q, rx_ovr_d;

  logic       sck_rise, sck_fall, lead_e, trail_e, sample_e, shift_e;
  logic       load, done;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sck_s1_q   <= 1'b0;
      sck_s2_q   <= 1'b0;
      sck_prev_q <= 1'b0;
      ss_s1_q    <= 1'b1;
      ss_s2_q    <= 1'b1;
      mosi_s1_q  <= 1'b0;
      mosi_s2_q  <= 1'b0;
    end else begin
      sck_s1_q   <= sck;
      sck_s2_q   <= sck_s1_q;
      sck_prev_q <= sck_s2_q;
      ss_s1_q    <= ss_n;
      ss_s2_q    <= ss_s1_q;
      mosi_s1_q  <= mosi;
      mosi_s2_q  <= mosi_s1_q;
    end
  end

  assign sck_rise = sck_s2_q & ~sck_prev_q;
  assign sck_fall = ~sck_s2_q & sck_prev_q;
  assign lead_e   = cpol_q ? sck_fall : sck_rise;
  assign trail_e  = cpol_q ? sck_rise : sck_fall;
  assign sample_e = cpha_q ? trail_e : lead_e;
  assign shift_e  = cpha_q ? lead_e : trail_e;

  always_comb begin
    state_d   = state_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    bit_cnt_d = bit_cnt_q;
    rx_sr_d   = rx_sr_q;
    tx_sr_d   = tx_sr_q;
    tx_buf_d  = tx_buf_q;
    tx_full_d = tx_full_q;
    rx_data_d = rx_data_q;
    rx_ne_d   = rx_ne_q;
    rx_ovr_d  = rx_ovr_q;
    load      = 1'b0;
    done      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // mode follows the pins only while deselected
        cpol_d = cpol;
        cpha_d = cpha;
        if (!ss_s2_q) begin
          state_d   = ST_ACTIVE;
          bit_cnt_d = 3'd0;
          load      = 1'b1;
        end
      end
      default: begin
        if (ss_s2_q) begin
          // deselect drops any partial byte; edges in this cycle are ignored
          state_d   = ST_IDLE;
          bit_cnt_d = 3'd0;
        end else begin
          if (sample_e) begin
            rx_sr_d   = {rx_sr_q[6:0], mosi_s2_q};
            bit_cnt_d = bit_cnt_q + 3'd1;
            done      = (bit_cnt_q == 3'd7);
          end
          if (shift_e) begin
            if (bit_cnt_q == 3'd0) load = 1'b1;
            else tx_sr_d = {tx_sr_q[6:0], 1'b0};
          end
        end
      end
    endcase

    if (rx_rd) begin
      rx_ne_d  = 1'b0;
      rx_ovr_d = 1'b0;
    end
    if (done) begin
      rx_data_d = rx_sr_d;
      rx_ne_d   = 1'b1;
      if (rx_ne_q && !rx_rd) rx_ovr_d = 1'b1;
    end

    // write is judged against the old tx_full, so a write coinciding with a
    // load from a full buffer is dropped while the buffer empties
    if (tx_wr && !tx_full_q) begin
      tx_buf_d  = tx_data;
      tx_full_d = 1'b1;
    end
    if (load) begin
      if (tx_full_q) begin
        tx_sr_d   = tx_buf_q;
        tx_full_d = 1'b0;
      end else begin
        tx_sr_d = 8'h00;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      bit_cnt_q <= 3'd0;
      rx_sr_q   <= 8'h00;
      tx_sr_q   <= 8'h00;
      tx_buf_q  <= 8'h00;
      tx_full_q <= 1'b0;
      rx_data_q <= 8'h00;
      rx_ne_q   <= 1'b0;
      rx_ovr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      bit_cnt_q <= bit_cnt_d;
      rx_sr_q   <= rx_sr_d;
      tx_sr_q   <= tx_sr_d;
      tx_buf_q  <= tx_buf_d;
      tx_full_q <= tx_full_d;
      rx_data_q <= rx_data_d;
      rx_ne_q   <= rx_ne_d;
      rx_ovr_q  <= rx_ovr_d;
    end
  end

  assign miso    = (state_q == ST_ACTIVE) & tx_sr_q[7];
  assign miso_oe = (state_q == ST_ACTIVE);
  assign busy    = (state_q == ST_ACTIVE) && (bit_cnt_q != 3'd0);
  assign tx_full = tx_full_q;
  assign rx_data = rx_data_q;
  assign rx_ne   = rx_ne_q;
  assign rx_ovr  = rx_ovr_q;

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed and randomized SPI master stimulus for spi_slave,
// checked against a behavioural model of the transmit buffer and receive flags.
module tb_spi_slave;

  localparam int HALF = 6;

  logic       clk = 1'b0;
  logic       rst_n, cpol, cpha, sck, ss_n, mosi, tx_wr, rx_rd;
  logic [7:0] tx_data;
  logic       miso, miso_oe, tx_full, rx_ne, rx_ovr, busy;
  logic [7:0] rx_data;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  bit         m_full, m_ne, m_ovr, m_cpol, m_cpha;
  logic [7:0] m_buf, m_sr, m_rdata;

  always #5 clk = ~clk;

  spi_slave dut (
    .clk(clk), .rst_n(rst_n), .cpol(cpol), .cpha(cpha), .sck(sck),
    .ss_n(ss_n), .mosi(mosi), .miso(miso), .miso_oe(miso_oe),
    .tx_data(tx_data), .tx_wr(tx_wr), .tx_full(tx_full),
    .rx_data(rx_data), .rx_ne(rx_ne), .rx_rd(rx_rd), .rx_ovr(rx_ovr),
    .busy(busy)
  );

  initial begin
    #5ms;
    $display("FAIL timeout: bench did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic void m_wr(input logic [7:0] d);
    if (!m_full) begin
      m_buf  = d;
      m_full = 1'b1;
    end
  endfunction

  function automatic void m_load();
    m_sr   = m_full ? m_buf : 8'h00;
    m_full = 1'b0;
  endfunction

  function automatic void m_rx_done(input logic [7:0] b, input bit rd);
    m_rdata = b;
    if (rd) m_ovr = 1'b0;
    else if (m_ne) m_ovr = 1'b1;
    m_ne = 1'b1;
  endfunction

  task automatic m_reset();
    m_full = 0; m_ne = 0; m_ovr = 0;
    m_buf = 8'h00; m_sr = 8'h00; m_rdata = 8'h00;
  endtask

  task automatic tx_write(input logic [7:0] d);
    tx_data = d;
    tx_wr   = 1'b1;
    m_wr(d);
    cyc(1);
    tx_wr   = 1'b0;
  endtask

  task automatic rd_pulse();
    rx_rd = 1'b1;
    cyc(1);
    rx_rd = 1'b0;
    m_ne  = 0;
    m_ovr = 0;
  endtask

  task automatic sel(input bit p, input bit h);
    cpol = p; cpha = h; m_cpol = p; m_cpha = h;
    sck  = p;
    cyc(4);
    ss_n = 1'b0;
    m_load();
    cyc(6);
    chk1("miso_oe_sel", miso_oe, 1'b1);
  endtask

  task automatic desel();
    ss_n = 1'b1;
    cyc(6);
    chk1("miso_oe_desel", miso_oe, 1'b0);
    chk1("busy_desel", busy, 1'b0);
    chk1("miso_idle", miso, 1'b0);
  endtask

  // second half of a sample phase; optionally lands rx_rd on the clk edge
  // where the slave acts on the final sample edge (3 edges after sck moves)
  task automatic half_rd(input bit rd);
    if (rd) begin
      cyc(2);
      rx_rd = 1'b1;
      cyc(1);
      rx_rd = 1'b0;
      cyc(HALF - 3);
    end else begin
      cyc(HALF);
    end
  endtask

  task automatic xfer(input logic [7:0] mo, input int nbits, input bit rd_last,
                      output logic [7:0] mi, output logic [7:0] exp_tx);
    mi = 8'h00;
    exp_tx = m_sr;
    for (int i = 0; i < nbits; i++) begin
      if (!m_cpha) begin
        mosi = mo[7-i];
        cyc(HALF);
        mi[7-i] = miso;
        sck = ~m_cpol;
        if (i == 7) m_rx_done(mo, rd_last);
        half_rd(i == 7 && rd_last);
        sck = m_cpol;
        if (i == 7) m_load();
      end else begin
        sck = ~m_cpol;
        if (i == 0) begin
          m_load();
          exp_tx = m_sr;
        end
        mosi = mo[7-i];
        cyc(HALF);
        mi[7-i] = miso;
        sck = m_cpol;
        if (i == 7) m_rx_done(mo, rd_last);
        half_rd(i == 7 && rd_last);
      end
    end
    if (!m_cpha) cyc(HALF);
  endtask

  task automatic chk_rx(input string tag);
    chk8({tag, "_rx_data"}, rx_data, m_rdata);
    chk1({tag, "_rx_ne"}, rx_ne, m_ne);
    chk1({tag, "_rx_ovr"}, rx_ovr, m_ovr);
    chk1({tag, "_tx_full"}, tx_full, m_full);
  endtask

  task automatic chk_reset(input string tag);
    chk1({tag, "_miso"}, miso, 1'b0);
    chk1({tag, "_miso_oe"}, miso_oe, 1'b0);
    chk1({tag, "_tx_full"}, tx_full, 1'b0);
    chk8({tag, "_rx_data"}, rx_data, 8'h00);
    chk1({tag, "_rx_ne"}, rx_ne, 1'b0);
    chk1({tag, "_rx_ovr"}, rx_ovr, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    logic [7:0] mi, e, a, b;
    int nb;

    rst_n = 1'b0; cpol = 0; cpha = 0; sck = 0; ss_n = 1; mosi = 0;
    tx_wr = 0; rx_rd = 0; tx_data = 8'h00;
    m_reset();
    cyc(3);
    chk_reset("reset");
    rst_n = 1'b1;
    cyc(3);

    // mode 0, buffered A5 out while 3C comes in
    tx_write(8'hA5);
    chk1("m0_tx_full_wr", tx_full, 1'b1);
    sel(0, 0);
    chk1("m0_tx_full_load", tx_full, 1'b0);
    xfer(8'h3C, 8, 0, mi, e);
    chk8("m0_miso", mi, e);
    chk8("m0_miso_a5", mi, 8'hA5);
    chk_rx("m0");
    chk8("m0_rx_3c", rx_data, 8'h3C);
    desel();
    rd_pulse();
    chk1("m0_rd_clear", rx_ne, 1'b0);

    // mode 3, nothing to send, two bytes without deselect -> overrun
    sel(1, 1);
    xfer(8'hF0, 8, 0, mi, e);
    chk8("m3_b0_miso", mi, 8'h00);
    chk_rx("m3_b0");
    xfer(8'h0F, 8, 0, mi, e);
    chk8("m3_b1_miso", mi, 8'h00);
    chk_rx("m3_b1");
    chk1("m3_ovr", rx_ovr, 1'b1);
    desel();
    rd_pulse();
    chk1("m3_ovr_clear", rx_ovr, 1'b0);

    // mode 1, read ack coincides with second byte completion
    a = 8'($urandom); b = 8'($urandom);
    sel(0, 1);
    xfer(a, 8, 0, mi, e);
    xfer(b, 8, 1, mi, e);
    chk_rx("m1_rdsame");
    chk1("m1_ne", rx_ne, 1'b1);
    chk1("m1_ovr", rx_ovr, 1'b0);
    desel();
    rd_pulse();

    // mode 2, deselect after 5 bits, then a full byte
    tx_write(8'($urandom));
    sel(1, 0);
    xfer(8'($urandom), 5, 0, mi, e);
    chk1("m2_busy_mid", busy, 1'b1);
    desel();
    chk_rx("m2_partial");
    b = 8'($urandom);
    sel(1, 0);
    xfer(b, 8, 0, mi, e);
    chk8("m2_miso", mi, e);
    chk_rx("m2_full");
    desel();

    // second write while full is ignored
    tx_write(8'h11);
    tx_write(8'h22);
    chk1("wr2_full", tx_full, 1'b1);
    sel(0, 0);
    xfer(8'($urandom), 8, 0, mi, e);
    chk8("wr2_miso", mi, 8'h11);
    chk_rx("wr2");
    desel();

    // reset in the middle of a byte
    sel(0, 0);
    tx_write(8'($urandom));
    xfer(8'($urandom), 4, 0, mi, e);
    rst_n = 1'b0;
    cyc(2);
    chk_reset("rst_mid");
    ss_n = 1'b1; sck = 1'b0;
    m_reset();
    cyc(1);
    rst_n = 1'b1;
    cyc(4);
    chk_rx("rst_after");

    // randomized transactions across all modes
    for (int it = 0; it < 12; it++) begin
      if ($urandom_range(1) == 1) tx_write(8'($urandom));
      sel(1'($urandom_range(1)), 1'($urandom_range(1)));
      if ($urandom_range(1) == 1) tx_write(8'($urandom));
      nb = 1 + int'($urandom_range(1));
      for (int k = 0; k < nb; k++) begin
        xfer(8'($urandom), 8, 0, mi, e);
        chk8("rnd_miso", mi, e);
        chk_rx("rnd");
      end
      desel();
      if ($urandom_range(1) == 1) rd_pulse();
      chk_rx("rnd_end");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
